// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator read-side logic.
package acc_pkg;

    localparam int ACC_WIDTH = 8;
    localparam int DROP_MAX  = 255;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] sum;
        logic [ACC_WIDTH-1:0] delta;
    } acc_sample_t;

endpackage

// File: rtl/acc_sample_fifo.sv
// First-word-fall-through FIFO for {sum, delta} samples; head is read combinationally.
module acc_sample_fifo
    import acc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = $bits(acc_sample_t)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign level = count_q;
    // Empty FIFO presents zeros rather than stale storage.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (push && (wr_ptr_q == gi[AW-1:0])) begin
                    mem_d[gi] = din;
                end
            end

            always_ff @(posedge clk) begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/acc_sum_reader.sv
// Periodically samples the accumulator sum, computes the delta to the last stored
// sample and queues {sum, delta} pairs on a valid/ready stream.
module acc_sum_reader
    import acc_pkg::*;
#(
    parameter int WIDTH    = ACC_WIDTH,
    parameter int DEPTH    = 4,
    parameter int PERIOD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         sum,
    input  logic                     en,
    input  logic [PERIOD_W-1:0]      period,
    output logic [WIDTH-1:0]         out_sum,
    output logic [WIDTH-1:0]         out_delta,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = 1;
    localparam logic [7:0]          DROP_SAT   = DROP_MAX[7:0];

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [7:0]          drop_q, drop_d;

    logic [PERIOD_W-1:0] eff_period;
    logic                strobe;
    logic                pop_fire;
    logic                push_ok;
    logic [WIDTH-1:0]    delta;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*WIDTH-1:0]  fifo_dout;

    assign eff_period = (period == '0) ? PERIOD_ONE : period;
    // Compare with >= so a period shrunk below the running count strobes at once.
    assign strobe     = en && (cnt_q >= (eff_period - PERIOD_ONE));
    assign out_valid  = !fifo_empty;
    assign pop_fire   = out_valid && out_ready;
    assign push_ok    = strobe && (!fifo_full || pop_fire);
    assign delta      = sum - prev_q;

    always_comb begin
        cnt_d  = cnt_q;
        prev_d = prev_q;
        drop_d = drop_q;
        if (!en || strobe) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PERIOD_ONE;
        end
        if (push_ok) begin
            prev_d = sum;
        end
        // A dropped sample leaves prev untouched so the next delta spans the gap.
        if (strobe && !push_ok && (drop_q != DROP_SAT)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            prev_q <= '0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            drop_q <= drop_d;
        end
    end

    acc_sample_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .din   ({sum, delta}),
        .pop   (pop_fire),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign {out_sum, out_delta} = fifo_dout;
    assign drop_cnt             = drop_q;

endmodule

// File: tb/tb_acc_sum_reader.sv
// Directed bench: stimulus queues hand-computed {sum, delta} entries; a monitor checks each popped head.
module tb_acc_sum_reader;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  sum;
    logic          en;
    logic [PW-1:0] period;
    logic [W-1:0]  out_sum;
    logic [W-1:0]  out_delta;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    level;
    logic [7:0]    drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    acc_sum_reader #(
        .WIDTH    (W),
        .DEPTH    (D),
        .PERIOD_W (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sum       (sum),
        .en        (en),
        .period    (period),
        .out_sum   (out_sum),
        .out_delta (out_delta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input int s, input int d);
        exp_q.push_back({s[7:0], d[7:0]});
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        tick();
        rst       = 1'b0;
    endtask

    // Monitor: a handshake visible at the negedge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got sum=%0d delta=%0d expected no entry",
                         out_sum, out_delta);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_sum, out_delta} !== mon_exp) begin
                    failures++;
                    $display("FAIL pop_entry: got sum=%0d delta=%0d expected sum=%0d delta=%0d",
                             out_sum, out_delta, mon_exp[15:8], mon_exp[7:0]);
                end else begin
                    $display("ok   pop_entry: sum=%0d delta=%0d", out_sum, out_delta);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        period    = '0;
        sum       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_level", level, 0);
        check("reset_valid", out_valid, 0);
        check("reset_drop", drop_cnt, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_out_delta", out_delta, 0);
        rst = 1'b0;

        // Basic sampling, period 4, sum ramps from 0.
        period    = 8'd4;
        out_ready = 1'b1;
        expect_entry(3, 3);
        expect_entry(7, 4);
        expect_entry(11, 4);
        expect_entry(15, 4);
        for (int c = 0; c < 16; c++) begin
            sum = c[7:0];
            en  = 1'b1;
            tick();
            check("basic_valid_timing", out_valid, ((c % 4) == 3) ? 1 : 0);
        end
        en = 1'b0;
        tick();
        tick();
        check("basic_drained", level, 0);

        // Period 0 behaves as 1.
        do_reset();
        period    = 8'd0;
        out_ready = 1'b1;
        sum       = 8'd5;
        expect_entry(5, 5);
        expect_entry(5, 0);
        expect_entry(5, 0);
        expect_entry(5, 0);
        en = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        tick();
        tick();
        check("p0_drained", level, 0);

        // Overflow: six samples into a four-entry FIFO with no consumer.
        do_reset();
        period    = 8'd1;
        out_ready = 1'b0;
        expect_entry(10, 10);
        expect_entry(20, 10);
        expect_entry(30, 10);
        expect_entry(40, 10);
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            sum = 8'(i * 10);
            tick();
        end
        en = 1'b0;
        check("ovf_level", level, 4);
        check("ovf_drop", drop_cnt, 2);
        check("ovf_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_head", {out_sum, out_delta}, {8'd10, 8'd10});
        end

        // Full FIFO, strobe with a simultaneous pop: accepted, delta spans the drops.
        expect_entry(70, 30);
        en        = 1'b1;
        sum       = 8'd70;
        out_ready = 1'b1;
        tick();
        check("full_pushpop_level", level, 4);
        check("full_pushpop_drop", drop_cnt, 2);
        en = 1'b0;
        repeat (5) tick();
        check("ovf_drained", level, 0);

        // Modular delta: 4 - 250 wraps to 10.
        do_reset();
        period    = 8'd1;
        out_ready = 1'b1;
        expect_entry(250, 250);
        expect_entry(4, 10);
        en  = 1'b1;
        sum = 8'd250;
        tick();
        sum = 8'd4;
        tick();
        en = 1'b0;
        tick();
        tick();
        check("mod_drained", level, 0);

        // Drop counter saturates.
        do_reset();
        period    = 8'd1;
        out_ready = 1'b0;
        sum       = 8'd9;
        en        = 1'b1;
        repeat (300) tick();
        en = 1'b0;
        check("drop_saturate", drop_cnt, 255);
        check("drop_sat_level", level, 4);

        // Reset mid-operation with level 3 and drop_cnt 7.
        do_reset();
        period    = 8'd1;
        out_ready = 1'b0;
        en        = 1'b1;
        for (int s = 1; s <= 11; s++) begin
            sum = s[7:0];
            tick();
        end
        en = 1'b0;
        expect_entry(1, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pre_rst_level", level, 3);
        check("pre_rst_drop", drop_cnt, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_level", level, 0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_drop", drop_cnt, 0);
        expect_entry(77, 77);
        en        = 1'b1;
        sum       = 8'd77;
        out_ready = 1'b1;
        tick();
        check("post_rst_level", level, 1);
        en = 1'b0;
        tick();
        tick();
        check("post_rst_drained", level, 0);

        check("expected_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_sum_reader.md
Name: acc_sum_reader

Overview:
- Read-side companion to the accumulator. Samples the accumulator's running `sum` output at a programmable interval.
- Computes the delta against the last stored sample and buffers {sum, delta} pairs in a small FIFO.
- The FIFO presents entries on a valid/ready stream toward the checker or host.
- Sits beside the accumulator, on the same `clk`/`rst` as the accumulator and its interface.

Parameters:
- WIDTH, 8, width of `sum`, `out_sum` and `out_delta`.
- DEPTH, 4, FIFO entries (power of two, >= 2).
- PERIOD_W, 8, width of the `period` input.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- sum  input  WIDTH  accumulator running sum.
- en  input  1  sampling enable.
- period  input  PERIOD_W  sample interval in cycles; 0 is treated as 1.
- out_sum  output  WIDTH  FIFO head: sampled sum.
- out_delta  output  WIDTH  FIFO head: sum minus previous stored sample, mod 2^WIDTH.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts head.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- drop_cnt  output  8  samples lost to a full FIFO; saturates at 255.

Behaviour:
- Reset (rst=1 at an edge):
  - interval counter cnt=0, prev_sample=0, FIFO emptied.
  - level=0, out_valid=0, drop_cnt=0; out_sum and out_delta read 0.
  - rst dominates all other inputs in the same cycle.
  - Reset mid-stream discards buffered entries with no handshake.
- Interval counter:
  - eff_period = (period==0) ? 1 : period.
  - en=0: cnt forced to 0, no strobes.
  - en=1: strobe asserts in any cycle with cnt >= eff_period-1; cnt then goes to 0. Otherwise cnt increments.
  - Shrinking period below cnt mid-count causes a strobe on the next cycle; no wrap-around.
  - period=1 gives a strobe every cycle. period=N gives the first strobe N cycles after en rises (cnt at 0), then every N cycles.
- Sample:
  - On a strobe cycle, `sum` is captured at that same edge.
  - entry.sum = sum; entry.delta = sum - prev_sample, truncated to WIDTH (modular wrap, unsigned).
- Push:
  - If the FIFO is not full, or a pop occurs in the same cycle, the entry is written and prev_sample <= sum.
  - Otherwise the entry is dropped, prev_sample is unchanged (the next delta spans the gap), and drop_cnt increments, saturating at 255.
- Pop: on out_valid && out_ready at an edge.
- Output timing:
  - FIFO is first-word-fall-through: out_valid = (level != 0); out_sum/out_delta are the head entry, combinational from storage.
  - Push-to-visible latency is 1 cycle: strobe at edge k gives out_valid=1 after edge k.
- Simultaneous push and pop:
  - Not empty: level unchanged, both happen.
  - Empty: push only (no fall-through bypass); the pop is impossible because out_valid=0.
  - Full: accepted, no drop.
- Handshake rules:
  - out_sum and out_delta are stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 is ignored.
- Pointers: wrap modulo DEPTH; level ranges 0..DEPTH.
- No combinational path from out_ready to out_valid.

Decomposition:
- Package acc_pkg:
  - ACC_WIDTH=8 default constant.
  - typedef struct packed {logic [WIDTH-1:0] sum; logic [WIDTH-1:0] delta;} acc_sample_t.
  - DROP_MAX=255 constant.
- One sub-module, acc_sample_fifo:
  - Synchronous FWFT FIFO of acc_sample_t, DEPTH entries.
  - Outputs: full, empty, level.
- Top level holds the interval counter, delta logic, prev_sample register and drop counter.

Test Plan:
- Basic sampling:
  - Stimulus: period=4, en=1, sum ramps +1 per cycle from 0, out_ready=1.
  - Required: entries every 4 cycles with sums 3,7,11,...; first delta=3, then delta=4 each.
- Period 0 as 1:
  - Stimulus: period=0, en=1, sum held at 5.
  - Required: one strobe per cycle; first entry {5,5}, subsequent entries {5,0}.
- Overflow and drop:
  - Stimulus: period=1, out_ready=0, sum=10,20,30,40,50,60 on consecutive cycles.
  - Required: level reaches 4, drop_cnt=2, FIFO holds 10,20,30,40 with deltas 10,10,10,10.
  - Then out_ready=1 and the next sample sum=70: entry delta=30 (70-40).
- Modular delta:
  - Stimulus: WIDTH=8, samples 250 then 4.
  - Required: second delta=10.
- Backpressure stability and simultaneous push/pop:
  - Stimulus: FIFO full, out_ready=1 on a strobe cycle.
  - Required: level stays 4, no drop.
  - Also: with out_ready=0, the head is unchanged across 10 cycles.
- Reset mid-operation:
  - Stimulus: level=3, drop_cnt=7, rst pulsed for 1 cycle.
  - Required: next cycle level=0, out_valid=0, drop_cnt=0.
  - Next sample's delta equals its raw sum (prev_sample=0).
